// File: rtl/bus_target.sv
`timescale 1ns/1ps
// bus_target: target-side responder for the 8-bit multiplexed req/ack bus.
// Decodes address-low / address-high / data phases, issues one local access
// with a bounded wait, and returns read data with sticky error reporting.
module bus_target #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 32,
   parameter logic [7:0]  ERR_DATA    = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_handshake_req,
   output logic        bus_handshake_ack,
   input  logic [1:0]  bus_state,
   input  logic        bus_io,
   input  logic [7:0]  bus_data_in,
   output logic [7:0]  bus_data_out,
   output logic        bus_output_enable,
   output logic [15:0] tgt_addr,
   output logic        tgt_io,
   output logic        tgt_read,
   output logic        tgt_write,
   output logic [7:0]  tgt_wdata,
   input  logic [7:0]  tgt_rdata,
   input  logic        tgt_ready,
   output logic        seq_err,
   output logic        timeout_err,
   input  logic        err_clear
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ACK
   } state_t;

   typedef enum logic [1:0] {
      EXP_ADDR_LOW,
      EXP_ADDR_HIGH,
      EXP_DATA
   } expect_t;

   state_t                 state_q, state_d;
   expect_t                exp_q, exp_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ack_q, ack_d;
   logic                   oe_q, oe_d;
   logic [7:0]             dout_q, dout_d;
   logic                   rd_q, rd_d;
   logic                   wr_q, wr_d;
   logic [15:0]            addr_q, addr_d;
   logic                   io_q, io_d;
   logic [7:0]             wdata_q, wdata_d;
   logic                   rdph_q, rdph_d;
   logic                   seq_err_q, seq_err_d;
   logic                   to_err_q, to_err_d;
   logic                   req_s;
   logic                   seq_set;
   logic                   to_set;

   assign req_s = sync_q[SYNC_STAGES-1];

   // State, synchronizer and output registers; async reset to idle values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         exp_q     <= EXP_ADDR_LOW;
         sync_q    <= '0;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         oe_q      <= 1'b0;
         dout_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         io_q      <= 1'b0;
         wdata_q   <= '0;
         rdph_q    <= 1'b0;
         seq_err_q <= 1'b0;
         to_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         oe_q      <= oe_d;
         dout_q    <= dout_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         io_q      <= io_d;
         wdata_q   <= wdata_d;
         rdph_q    <= rdph_d;
         seq_err_q <= seq_err_d;
         to_err_q  <= to_err_d;
      end
   end

   // Next-state logic: phase decode, local access with timeout, handshake.
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      oe_d    = oe_q;
      dout_d  = dout_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      io_d    = io_q;
      wdata_d = wdata_q;
      rdph_d  = rdph_q;
      seq_set = 1'b0;
      to_set  = 1'b0;

      sync_d[0] = bus_handshake_req;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      case (state_q)
         ST_IDLE: begin
            ack_d = 1'b0;
            oe_d  = 1'b0;
            if (req_s) begin
               rdph_d = (bus_state == 2'b10);
               case (bus_state)
                  2'b00: begin
                     addr_d[7:0] = bus_data_in;
                     exp_d       = EXP_ADDR_HIGH;
                     state_d     = ST_ACK;
                  end
                  2'b01: begin
                     if (exp_q == EXP_ADDR_HIGH) begin
                        addr_d[15:8] = bus_data_in;
                        exp_d        = EXP_DATA;
                     end else begin
                        seq_set = 1'b1;
                     end
                     state_d = ST_ACK;
                  end
                  default: begin
                     exp_d = EXP_ADDR_LOW;
                     if (exp_q == EXP_DATA) begin
                        io_d  = bus_io;
                        cnt_d = '0;
                        if (bus_state[0]) begin
                           wdata_d = bus_data_in;
                           wr_d    = 1'b1;
                        end else begin
                           rd_d = 1'b1;
                        end
                        state_d = ST_ACCESS;
                     end else begin
                        seq_set = 1'b1;
                        if (!bus_state[0]) begin
                           dout_d = ERR_DATA;
                        end
                        state_d = ST_ACK;
                     end
                  end
               endcase
            end
         end
         ST_ACCESS: begin
            if (tgt_ready) begin
               if (rd_q) begin
                  dout_d = tgt_rdata;
               end
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = ST_ACK;
            end else if (cnt_q == CNT_LAST) begin
               if (rd_q) begin
                  dout_d = ERR_DATA;
               end
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               to_set  = 1'b1;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ACK: begin
            if (req_s) begin
               ack_d = 1'b1;
               oe_d  = rdph_q;
            end else begin
               ack_d   = 1'b0;
               oe_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A flag being set in the same cycle as err_clear stays set.
      seq_err_d = seq_set | (seq_err_q & ~err_clear);
      to_err_d  = to_set  | (to_err_q  & ~err_clear);
   end

   assign bus_handshake_ack = ack_q;
   assign bus_output_enable = oe_q;
   assign bus_data_out      = dout_q;
   assign tgt_addr          = addr_q;
   assign tgt_io            = io_q;
   assign tgt_read          = rd_q;
   assign tgt_write         = wr_q;
   assign tgt_wdata         = wdata_q;
   assign seq_err           = seq_err_q;
   assign timeout_err       = to_err_q;

endmodule

// File: tb/tb_bus_target.sv
`timescale 1ns/1ps
// tb_bus_target: directed transactions against bus_target with a simple
// local-port responder and hand-computed expected values.
module tb_bus_target;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_handshake_req = 1'b0;
   logic        bus_handshake_ack;
   logic [1:0]  bus_state = 2'b00;
   logic        bus_io = 1'b0;
   logic [7:0]  bus_data_in = 8'h00;
   logic [7:0]  bus_data_out;
   logic        bus_output_enable;
   logic [15:0] tgt_addr;
   logic        tgt_io;
   logic        tgt_read;
   logic        tgt_write;
   logic [7:0]  tgt_wdata;
   logic [7:0]  tgt_rdata = 8'h00;
   logic        tgt_ready;
   logic        seq_err;
   logic        timeout_err;
   logic        err_clear = 1'b0;

   int   n_checks = 0;
   int   n_errors = 0;

   // responder configuration (written by main only)
   logic ready_en  = 1'b1;
   int   ready_lat = 1;

   // responder / monitor state (written by responder only)
   int       scyc = 0;
   int       rd_total = 0;
   int       wr_total = 0;
   logic [7:0] wdata_seen = 8'h00;

   bus_target #(
      .SYNC_STAGES(2),
      .TIMEOUT    (32),
      .ERR_DATA   (8'hFF)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .bus_handshake_req(bus_handshake_req),
      .bus_handshake_ack(bus_handshake_ack),
      .bus_state        (bus_state),
      .bus_io           (bus_io),
      .bus_data_in      (bus_data_in),
      .bus_data_out     (bus_data_out),
      .bus_output_enable(bus_output_enable),
      .tgt_addr         (tgt_addr),
      .tgt_io           (tgt_io),
      .tgt_read         (tgt_read),
      .tgt_write        (tgt_write),
      .tgt_wdata        (tgt_wdata),
      .tgt_rdata        (tgt_rdata),
      .tgt_ready        (tgt_ready),
      .seq_err          (seq_err),
      .timeout_err      (timeout_err),
      .err_clear        (err_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Local-port responder: raises tgt_ready after ready_lat strobe cycles.
   initial begin
      tgt_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (tgt_read || tgt_write) scyc++;
         else scyc = 0;
         if (tgt_read) rd_total++;
         if (tgt_write) begin
            wr_total++;
            wdata_seen = tgt_wdata;
         end
         tgt_ready = (tgt_read || tgt_write) && ready_en && (scyc >= ready_lat);
      end
   end

   // One full four-phase handshake; lat counts clocks from req rise to ack.
   task automatic bus_txn(input logic [1:0] ph, input logic io, input logic [7:0] b,
                          output logic [7:0] rdata, output logic oe_at_ack, output int lat);
      int w;
      @(negedge clk);
      bus_state = ph;
      bus_io = io;
      bus_data_in = b;
      bus_handshake_req = 1'b1;
      lat = 0;
      rdata = 8'h00;
      oe_at_ack = 1'b0;
      while (!bus_handshake_ack && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      if (!bus_handshake_ack) begin
         check("ack_rise", {31'd0, bus_handshake_ack}, 32'd1);
         bus_handshake_req = 1'b0;
         return;
      end
      rdata = bus_data_out;
      oe_at_ack = bus_output_enable;
      bus_handshake_req = 1'b0;
      w = 0;
      while (bus_handshake_ack && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ack_fall", {31'd0, bus_handshake_ack}, 32'd0);
      check("oe_fall", {31'd0, bus_output_enable}, 32'd0);
      bus_state = 2'b00;
      bus_data_in = 8'hEE;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic       oe;
      int         lat;
      int         rd0, wr0, w;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, bus_handshake_ack}, 32'd0);
      check("rst_oe", {31'd0, bus_output_enable}, 32'd0);
      check("rst_dout", {24'd0, bus_data_out}, 32'h0);
      check("rst_rd", {31'd0, tgt_read}, 32'd0);
      check("rst_wr", {31'd0, tgt_write}, 32'd0);
      check("rst_addr", {16'd0, tgt_addr}, 32'h0);
      check("rst_io", {31'd0, tgt_io}, 32'd0);
      check("rst_wdata", {24'd0, tgt_wdata}, 32'h0);
      check("rst_seq", {31'd0, seq_err}, 32'd0);
      check("rst_to", {31'd0, timeout_err}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // sequence errors straight after reset
      bus_txn(2'b01, 1'b0, 8'h99, rd, oe, lat);
      check("seq_hi_lat", lat, 32'd4);
      check("seq_hi_err", {31'd0, seq_err}, 32'd1);
      check("seq_hi_addr", {16'd0, tgt_addr}, 32'h0);
      rd0 = rd_total;
      bus_txn(2'b10, 1'b0, 8'h00, rd, oe, lat);
      check("seq_rd_data", {24'd0, rd}, 32'hFF);
      check("seq_rd_oe", {31'd0, oe}, 32'd1);
      check("seq_rd_lat", lat, 32'd4);
      check("seq_rd_nostrobe", rd_total - rd0, 32'd0);
      @(negedge clk); err_clear = 1'b1;
      @(negedge clk); err_clear = 1'b0;
      check("seq_clear", {31'd0, seq_err}, 32'd0);

      // write 0xA5 to 0x1234, ready after 3 cycles
      ready_en = 1'b1; ready_lat = 3;
      bus_txn(2'b00, 1'b0, 8'h34, rd, oe, lat);
      check("wr_alo_lat", lat, 32'd4);
      check("wr_alo_oe", {31'd0, oe}, 32'd0);
      bus_txn(2'b01, 1'b0, 8'h12, rd, oe, lat);
      check("wr_ahi_lat", lat, 32'd4);
      wr0 = wr_total;
      bus_txn(2'b11, 1'b1, 8'hA5, rd, oe, lat);
      check("wr_lat", lat, 32'd7);
      check("wr_oe", {31'd0, oe}, 32'd0);
      check("wr_addr", {16'd0, tgt_addr}, 32'h1234);
      check("wr_cycles", wr_total - wr0, 32'd3);
      check("wr_wdata", {24'd0, wdata_seen}, 32'hA5);
      check("wr_io", {31'd0, tgt_io}, 32'd1);
      check("wr_seq", {31'd0, seq_err}, 32'd0);

      // read 0x8000, ready on first access cycle
      ready_lat = 1; tgt_rdata = 8'h5A;
      bus_txn(2'b00, 1'b0, 8'h00, rd, oe, lat);
      bus_txn(2'b01, 1'b0, 8'h80, rd, oe, lat);
      rd0 = rd_total;
      bus_txn(2'b10, 1'b0, 8'h00, rd, oe, lat);
      check("rd_data", {24'd0, rd}, 32'h5A);
      check("rd_oe", {31'd0, oe}, 32'd1);
      check("rd_lat", lat, 32'd5);
      check("rd_cycles", rd_total - rd0, 32'd1);
      check("rd_addr", {16'd0, tgt_addr}, 32'h8000);
      check("rd_io", {31'd0, tgt_io}, 32'd0);

      // read timeout
      ready_en = 1'b0; tgt_rdata = 8'h3C;
      bus_txn(2'b00, 1'b0, 8'h01, rd, oe, lat);
      bus_txn(2'b01, 1'b0, 8'h02, rd, oe, lat);
      rd0 = rd_total;
      bus_txn(2'b10, 1'b1, 8'h00, rd, oe, lat);
      check("to_data", {24'd0, rd}, 32'hFF);
      check("to_oe", {31'd0, oe}, 32'd1);
      check("to_lat", lat, 32'd36);
      check("to_cycles", rd_total - rd0, 32'd32);
      check("to_flag", {31'd0, timeout_err}, 32'd1);
      check("to_seq", {31'd0, seq_err}, 32'd0);
      @(negedge clk); err_clear = 1'b1;
      @(negedge clk); err_clear = 1'b0;
      check("to_clear", {31'd0, timeout_err}, 32'd0);

      // restart with a second address-low phase
      ready_en = 1'b1; ready_lat = 1;
      bus_txn(2'b00, 1'b0, 8'h11, rd, oe, lat);
      bus_txn(2'b00, 1'b0, 8'h22, rd, oe, lat);
      bus_txn(2'b01, 1'b0, 8'h33, rd, oe, lat);
      wr0 = wr_total;
      bus_txn(2'b11, 1'b0, 8'h77, rd, oe, lat);
      check("rs_addr", {16'd0, tgt_addr}, 32'h3322);
      check("rs_seq", {31'd0, seq_err}, 32'd0);
      check("rs_cycles", wr_total - wr0, 32'd1);
      check("rs_wdata", {24'd0, wdata_seen}, 32'h77);

      // async reset during an access
      ready_en = 1'b0;
      bus_txn(2'b00, 1'b0, 8'h55, rd, oe, lat);
      bus_txn(2'b01, 1'b0, 8'h66, rd, oe, lat);
      @(negedge clk);
      bus_state = 2'b10; bus_data_in = 8'h00; bus_handshake_req = 1'b1;
      w = 0;
      while (!tgt_read && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ar_in_access", {31'd0, tgt_read}, 32'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("ar_rd", {31'd0, tgt_read}, 32'd0);
      check("ar_ack", {31'd0, bus_handshake_ack}, 32'd0);
      check("ar_oe", {31'd0, bus_output_enable}, 32'd0);
      check("ar_addr", {16'd0, tgt_addr}, 32'h0);
      bus_handshake_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ready_en = 1'b1; ready_lat = 2;
      repeat (2) @(negedge clk);
      bus_txn(2'b00, 1'b0, 8'hCD, rd, oe, lat);
      bus_txn(2'b01, 1'b0, 8'hAB, rd, oe, lat);
      wr0 = wr_total;
      bus_txn(2'b11, 1'b1, 8'h3C, rd, oe, lat);
      check("ar_wr_addr", {16'd0, tgt_addr}, 32'hABCD);
      check("ar_wr_cycles", wr_total - wr0, 32'd2);
      check("ar_wr_wdata", {24'd0, wdata_seen}, 32'h3C);
      check("ar_wr_lat", lat, 32'd6);
      check("ar_wr_seq", {31'd0, seq_err}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_target.md
Name: bus_target

Overview:
- Target-side responder for the 8-bit multiplexed handshake bus driven by the CPU bus interface.
- Sits directly downstream of the initiator. It decodes the three-phase transaction (address low, address high, data) over a four-phase req/ack handshake.
- Issues one access on a simple local memory/IO port and returns read data onto the bus.
- Checks phase ordering and bounds local-port latency with a timeout.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on bus_handshake_req before use (min 1).
- TIMEOUT, 32, max cycles in ACCESS waiting for tgt_ready (min 2).
- ERR_DATA, 8'hFF, read data returned on timeout or out-of-order data phase.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- bus_handshake_req  in  1  initiator request, four-phase
- bus_handshake_ack  out  1  target acknowledge
- bus_state  in  2  phase: 00 addr low, 01 addr high, 10 read data, 11 write data
- bus_io  in  1  IO-space qualifier from initiator
- bus_data_in  in  8  initiator-driven bus byte (address or write data)
- bus_data_out  out  8  target-driven read byte
- bus_output_enable  out  1  target drives bus
- tgt_addr  out  16  latched address {high, low}
- tgt_io  out  1  latched bus_io of the data phase
- tgt_read  out  1  read request, level, held until tgt_ready
- tgt_write  out  1  write request, level, held until tgt_ready
- tgt_wdata  out  8  write data
- tgt_rdata  in  8  read data, valid with tgt_ready
- tgt_ready  in  1  local access complete
- seq_err  out  1  sticky: out-of-order phase seen
- timeout_err  out  1  sticky: local access timed out
- err_clear  in  1  clears both sticky flags (one cycle)

Behaviour:
- Clock, reset, polarity: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: ack=0, bus_output_enable=0, bus_data_out=0, tgt_read=0, tgt_write=0, tgt_addr=0, tgt_io=0, tgt_wdata=0, seq_err=0, timeout_err=0. State is IDLE, expected phase is ADDR_LOW, synchronizer is cleared.
- Synchronizer: req_s is bus_handshake_req delayed by SYNC_STAGES flops. bus_state, bus_io and bus_data_in are sampled only on the edge where IDLE sees req_s=1. They are stable then, because the initiator holds them while req is high.
- State IDLE, ack=0: on req_s=1, capture phase and byte, then:
  - 00: tgt_addr[7:0] <= byte, expected <= ADDR_HIGH, go to ACK.
  - 01: if expected==ADDR_HIGH, tgt_addr[15:8] <= byte and expected <= DATA. Otherwise set seq_err and leave the address unchanged. Go to ACK.
  - 1x: if expected==DATA, latch tgt_io, latch tgt_wdata (on 11), go to ACCESS. Otherwise set seq_err, set bus_data_out=ERR_DATA (on 10), go to ACK with no local access. In both cases expected <= ADDR_LOW.
  - Phase 00 is always legal and restarts the sequence.
- State ACCESS:
  - tgt_read (phase 10) or tgt_write (phase 11) is high and held until the edge where tgt_ready=1.
  - On that edge: read latches tgt_rdata into bus_data_out; go to ACK.
  - A cycle counter starts at 0 on entry. If TIMEOUT cycles elapse without tgt_ready, drop the strobe, set timeout_err, bus_data_out=ERR_DATA (read), go to ACK.
  - tgt_ready outside ACCESS is ignored.
- State ACK:
  - ack=1, registered, so it rises the cycle after entry.
  - bus_output_enable=1 only for a read data phase; bus_data_out is stable throughout.
  - On req_s=0: ack<=0 and oe<=0 on the same edge, go to IDLE.
  - A new transaction is never accepted until req_s is seen low.
- Minimum latency, req pin rising to ack:
  - Address phase: SYNC_STAGES+2 cycles.
  - Data phase with tgt_ready combinationally high: SYNC_STAGES+3 cycles.
- err_clear: clears the flags. A simultaneous error set wins over the clear.
- Reset mid-transaction: all outputs return to reset values immediately and expected=ADDR_LOW. The initiator must restart.
- bus_output_enable is never high while the initiator drives (address and write phases).

Test Plan:
- Write: addr 0x34, 0x12, data 0xA5 phase 11, tgt_ready after 3 cycles -> tgt_addr=0x1234, tgt_write high exactly 3 cycles with tgt_wdata=0xA5, three clean req/ack cycles, seq_err=0.
- Read: addr 0x00, 0x80, phase 10, tgt_rdata=0x5A with tgt_ready on the first ACCESS cycle -> bus_data_out=0x5A and oe=1 while ack=1, oe drops with ack.
- Timeout: read with tgt_ready held low -> after 32 ACCESS cycles tgt_read falls, ack rises with data 0xFF, timeout_err=1. err_clear -> 0.
- Sequence error: phase 01 directly after reset -> acked, seq_err=1, tgt_addr unchanged. Then phase 10 without address -> acked with 0xFF, no tgt_read pulse.
- Restart: addr low 0x11, then addr low 0x22, addr high 0x33, write -> tgt_addr=0x3322, no seq_err.
- Async reset asserted while in ACCESS -> tgt_read, ack and oe low without a clock edge. The following full write completes normally.
